// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer wrapped around a combinational ALU: it reads operands from a
// 4-entry register file, checks an ARM condition code and writes back the result and flags.
module alu_issue_seq #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_cond,
  input  logic             cmd_s,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_rn,
  input  logic [1:0]       cmd_rm,
  input  logic             cmd_imm_en,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  output logic             rsp_executed,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       flags,
  input  logic [1:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t           state_reg;
  logic [1:0]       rd_reg;
  logic             s_reg;
  logic [3:0]       cond_reg;
  logic [3:0]       new_flags_reg;
  logic [WIDTH-1:0] rf [4];

  // Odd condition codes are the negation of the even code below them; 1111 negates AL.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  // Operands are latched at capture: nothing can write the register file before EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_executed  <= 1'b0;
      rsp_result    <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_ctrl      <= 2'b00;
      flags         <= 4'b0000;
      rd_reg        <= 2'b00;
      s_reg         <= 1'b0;
      cond_reg      <= 4'b0000;
      new_flags_reg <= 4'b0000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            state_reg <= EXEC;
            cmd_ready <= 1'b0;
            alu_a     <= rf[cmd_rn];
            alu_b     <= cmd_imm_en ? cmd_imm : rf[cmd_rm];
            alu_ctrl  <= cmd_op;
            rd_reg    <= cmd_rd;
            s_reg     <= cmd_s;
            cond_reg  <= cmd_cond;
          end
        end
        EXEC: begin
          state_reg     <= WB;
          alu_a         <= '0;
          alu_b         <= '0;
          alu_ctrl      <= 2'b00;
          rsp_valid     <= 1'b1;
          rsp_executed  <= cond_pass(cond_reg, flags);
          rsp_result    <= alu_result;
          new_flags_reg <= alu_flags;
        end
        WB: begin
          state_reg <= IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          if (rsp_executed && s_reg) flags <= new_flags_reg;
        end
        default: begin
          state_reg <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Flop-based register file: needs async reset and a combinational debug read port.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rf
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rf[gi] <= '0;
        end else if (state_reg == WB && rsp_executed && rd_reg == 2'(gi)) begin
          rf[gi] <= rsp_result;
        end
      end
    end
  endgenerate

  assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural ALU stub plus an architectural register/flag model,
// directed scenarios followed by randomized commands.
module tb_alu_issue_seq;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_op;
  logic [3:0]   cmd_cond;
  logic         cmd_s;
  logic [1:0]   cmd_rd, cmd_rn, cmd_rm;
  logic         cmd_imm_en;
  logic [W-1:0] cmd_imm;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [1:0]   alu_ctrl;
  logic [3:0]   alu_flags;
  logic         rsp_valid, rsp_executed;
  logic [W-1:0] rsp_result;
  logic [3:0]   flags;
  logic [1:0]   dbg_addr;
  logic [W-1:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_regs [4];
  logic [3:0]   m_flags;
  logic         last_exec;
  logic [W-1:0] last_res;

  alu_issue_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cond(cmd_cond), .cmd_s(cmd_s), .cmd_rd(cmd_rd),
    .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .alu_flags(alu_flags), .rsp_valid(rsp_valid), .rsp_executed(rsp_executed),
    .rsp_result(rsp_result), .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU behaviour from integer arithmetic: returns {N,Z,C,V,result}.
  function automatic logic [8:0] alu_model(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
    int ua, ub, sa, sb, u, s;
    logic [4:0] r;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = (ua >= 16) ? ua - 32 : ua;
    sb = (ub >= 16) ? ub - 32 : ub;
    c = 1'b0; v = 1'b0; r = '0;
    case (op)
      2'd0: begin u = ua + ub; s = sa + sb; c = (u >= 32); v = (s > 15) || (s < -16); r = u[4:0]; end
      2'd1: begin u = ua - ub; s = sa - sb; c = (ua >= ub); v = (s > 15) || (s < -16); r = u[4:0]; end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {r[4], (r == 5'd0), c, v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_ctrl, alu_a, alu_b);

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;              4'h1: return !z;
      4'h2: return cf;             4'h3: return !cf;
      4'h4: return n;              4'h5: return !n;
      4'h6: return v;              4'h7: return !v;
      4'h8: return cf && !z;       4'h9: return !cf || z;
      4'hA: return n == v;         4'hB: return n != v;
      4'hC: return !z && (n == v); 4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_flags = 4'b0000;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_flags"}, 32'(flags), 32'(m_flags));
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check_eq($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(m_regs[i]));
    end
  endtask

  task automatic read_reg(input int idx, output logic [W-1:0] val);
    dbg_addr = 2'(idx);
    #1;
    val = dbg_data;
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [3:0] cond, input logic s,
                           input logic [1:0] rd, input logic [1:0] rn, input logic [1:0] rm,
                           input logic imm_en, input logic [W-1:0] imm);
    cmd_valid = 1'b1; cmd_op = op; cmd_cond = cond; cmd_s = s;
    cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_imm_en = imm_en; cmd_imm = imm;
  endtask

  task automatic scramble_cmd();
    cmd_op = 2'($urandom_range(3, 0)); cmd_cond = 4'($urandom_range(15, 0));
    cmd_s = 1'($urandom_range(1, 0)); cmd_rd = 2'($urandom_range(3, 0));
    cmd_rn = 2'($urandom_range(3, 0)); cmd_rm = 2'($urandom_range(3, 0));
    cmd_imm_en = 1'($urandom_range(1, 0)); cmd_imm = 5'($urandom_range(31, 0));
  endtask

  // Called at posedge+1 while IDLE; returns at posedge+5 of the cycle after WB.
  task automatic issue(input logic [1:0] op, input logic [3:0] cond, input logic s,
                       input logic [1:0] rd, input logic [1:0] rn, input logic [1:0] rm,
                       input logic imm_en, input logic [W-1:0] imm, input logic hold_valid);
    logic [W-1:0] ea, eb, er;
    logic [3:0]   ef;
    logic         pass;
    int           guard;
    guard = 0;
    while (!cmd_ready && guard < 10) begin @(posedge clk); #1; guard++; end
    check_eq("ready_before_cmd", 32'(cmd_ready), 32'd1);
    ea = m_regs[rn];
    eb = imm_en ? imm : m_regs[rm];
    {ef, er} = alu_model(op, ea, eb);
    pass = cond_ok(cond, m_flags);
    drive_cmd(op, cond, s, rd, rn, rm, imm_en, imm);
    @(posedge clk); #1;
    check_eq("exec_ready", 32'(cmd_ready), 32'd0);
    check_eq("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("exec_alu_a", 32'(alu_a), 32'(ea));
    check_eq("exec_alu_b", 32'(alu_b), 32'(eb));
    check_eq("exec_alu_ctrl", 32'(alu_ctrl), 32'(op));
    cmd_valid = hold_valid;
    scramble_cmd();
    @(posedge clk); #1;
    check_eq("wb_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("wb_executed", 32'(rsp_executed), 32'(pass));
    check_eq("wb_result", 32'(rsp_result), 32'(er));
    check_eq("wb_alu_a_idle", 32'(alu_a), 32'd0);
    check_eq("wb_ready", 32'(cmd_ready), 32'd0);
    last_exec = rsp_executed;
    last_res  = rsp_result;
    cmd_valid = 1'b0;
    if (pass) m_regs[rd] = er;
    if (pass && s) m_flags = ef;
    @(posedge clk); #1;
    check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_ready", 32'(cmd_ready), 32'd1);
    check_state("post");
  endtask

  // Reset asserted in EXEC (in_wb=0) or WB (in_wb=1) must abort without side effects.
  task automatic abort_cmd(input logic in_wb);
    drive_cmd(2'd0, 4'hE, 1'b1, 2'd1, 2'd0, 2'd0, 1'b1, 5'd9);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (in_wb) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("abort_ready", 32'(cmd_ready), 32'd1);
    check_eq("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("abort_alu_a", 32'(alu_a), 32'd0);
    check_state("abort");
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("abort_hold_rsp", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk); reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("after_abort_rsp", 32'(rsp_valid), 32'd0);
    end
    check_state("after_abort");
  endtask

  initial begin
    logic [W-1:0] rv;
    reset = 1'b0; cmd_valid = 1'b0; dbg_addr = 2'd0;
    cmd_op = '0; cmd_cond = '0; cmd_s = 1'b0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0;
    cmd_imm_en = 1'b0; cmd_imm = '0; last_exec = 1'b0; last_res = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    end
    check_eq("rst_executed", 32'(rsp_executed), 32'd0);
    check_eq("rst_result", 32'(rsp_result), 32'd0);
    check_eq("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check_state("rst");
    @(posedge clk); #1;

    issue(2'd0, 4'hE, 1'b1, 2'd1, 2'd0, 2'd0, 1'b1, 5'd7, 1'b0);
    check_eq("add_res", 32'(last_res), 32'd7);
    read_reg(1, rv); check_eq("add_r1", 32'(rv), 32'd7);
    check_eq("add_flags", 32'(flags), 32'b0000);
    @(posedge clk); #1;

    issue(2'd1, 4'hE, 1'b1, 2'd2, 2'd1, 2'd0, 1'b1, 5'd7, 1'b1);
    check_eq("sub_res", 32'(last_res), 32'd0);
    check_eq("sub_flags", 32'(flags), 32'b0110);
    @(posedge clk); #1;

    issue(2'd3, 4'h1, 1'b0, 2'd3, 2'd1, 2'd0, 1'b1, 5'd24, 1'b0);
    check_eq("ne_exec", 32'(last_exec), 32'd0);
    read_reg(3, rv); check_eq("ne_r3", 32'(rv), 32'd0);
    check_eq("ne_flags", 32'(flags), 32'b0110);
    @(posedge clk); #1;
    issue(2'd3, 4'h0, 1'b0, 2'd3, 2'd1, 2'd0, 1'b1, 5'd24, 1'b0);
    read_reg(3, rv); check_eq("eq_r3", 32'(rv), 32'd31);
    @(posedge clk); #1;

    issue(2'd0, 4'hE, 1'b0, 2'd1, 2'd1, 2'd0, 1'b1, 5'd8, 1'b0);
    @(posedge clk); #1;
    issue(2'd0, 4'hE, 1'b1, 2'd1, 2'd1, 2'd0, 1'b1, 5'd1, 1'b0);
    check_eq("ovf_res", 32'(last_res), 32'd16);
    check_eq("ovf_flags", 32'(flags), 32'b1001);
    @(posedge clk); #1;
    issue(2'd0, 4'hA, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 5'd1, 1'b0);
    check_eq("ge_exec", 32'(last_exec), 32'd1);
    @(posedge clk); #1;
    issue(2'd0, 4'hB, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 5'd1, 1'b0);
    check_eq("lt_exec", 32'(last_exec), 32'd0);
    @(posedge clk); #1;

    abort_cmd(1'b0);
    abort_cmd(1'b1);

    for (int k = 0; k < 150; k++) begin
      logic [3:0] c;
      c = ($urandom_range(3, 0) == 0) ? 4'hE : 4'($urandom_range(15, 0));
      issue(2'($urandom_range(3, 0)), c, 1'($urandom_range(1, 0)),
            2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
            1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)));
      if ($urandom_range(1, 0) == 1) begin @(posedge clk); #1; end
      else begin @(posedge clk); #1; end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
